// File: rtl/avalon_write_master.sv
// avalon_write_master
//
// Avalon-MM write master for the mining-core user logic. A go strobe latches
// a base byte address and a byte length; user data is buffered in an
// internal show-ahead FIFO and drained to the memory fabric one word per
// accepted bus cycle. control_done is high whenever the master is idle.
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   control_fixed_location      1 = keep the same address for every word
//   control_write_base          start byte address
//   control_write_length        transfer byte count (low bits ignored)
//   control_go                  single-cycle start strobe
//   control_done                high while idle
//   user_write_buffer           push user_buffer_data into the FIFO
//   user_buffer_data            push data
//   user_buffer_full            FIFO holds FIFODEPTH words
//   master_address              bus byte address
//   master_write                bus write request
//   master_byteenable           always all ones
//   master_writedata            FIFO head word
//   master_waitrequest          slave stall
module avalon_write_master #(
  parameter int ADDRESSWIDTH    = 28,
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int FIFODEPTH       = 16,
  parameter int FIFODEPTHLOG2   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    control_write_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_write_buffer,
  input  logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_buffer_full,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic [ADDRESSWIDTH-1:0] STEP     = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] LOW_MASK = ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
  localparam logic [FIFODEPTHLOG2:0]  FULL_CNT = (FIFODEPTHLOG2 + 1)'(FIFODEPTH);

  logic [0:0]              state;
  logic [ADDRESSWIDTH-1:0] address;
  logic [ADDRESSWIDTH-1:0] remaining;
  logic                    fixed;

  logic [DATAWIDTH-1:0]     mem [FIFODEPTH];
  logic [FIFODEPTHLOG2-1:0] rd_ptr;
  logic [FIFODEPTHLOG2-1:0] wr_ptr;
  logic [FIFODEPTHLOG2:0]   count;
  logic [FIFODEPTHLOG2:0]   count_next;

  logic push;
  logic fifo_empty;
  logic accept;

  // A push while full is dropped outright; a pop is simply a bus accept.
  assign push       = user_write_buffer & ~user_buffer_full;
  assign fifo_empty = (count == '0);
  assign accept     = master_write & ~master_waitrequest;
  assign count_next = count + (FIFODEPTHLOG2 + 1)'(push) - (FIFODEPTHLOG2 + 1)'(accept);

  // Storage has no reset: contents are only visible when count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= user_buffer_data;
    end
  end

  // Full is registered from the next count so it is exact on every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      user_buffer_full <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count            <= count_next;
      user_buffer_full <= (count_next == FULL_CNT);
    end
  end

  // A go with a sub-word length leaves remaining at zero, so XFER lasts one
  // cycle and no write is issued. The transfer ends either on the accept of
  // the last word or right away when nothing remains.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      address   <= '0;
      remaining <= '0;
      fixed     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (control_go) begin
            state     <= XFER;
            address   <= control_write_base;
            remaining <= control_write_length & ~LOW_MASK;
            fixed     <= control_fixed_location;
          end
        end
        default: begin
          if (accept) begin
            remaining <= remaining - STEP;
            if (!fixed) begin
              address <= address + STEP;
            end
          end
          if ((remaining == '0) || (accept && (remaining == STEP))) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign control_done      = (state == IDLE);
  assign master_write      = (state == XFER) & ~fifo_empty & (remaining != '0);
  assign master_address    = address;
  assign master_writedata  = mem[rd_ptr];
  assign master_byteenable = '1;

endmodule

// File: tb/tb_avalon_write_master.sv
// Testbench for avalon_write_master: table-driven per-cycle vectors plus
// hand-built sequences for bursts with stalls, overflow, starvation and
// reset in the middle of a transfer.
module tb_avalon_write_master;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          control_fixed_location;
  logic [AW-1:0] control_write_base;
  logic [AW-1:0] control_write_length;
  logic          control_go;
  logic          control_done;
  logic          user_write_buffer;
  logic [DW-1:0] user_buffer_data;
  logic          user_buffer_full;
  logic [AW-1:0] master_address;
  logic          master_write;
  logic [BW-1:0] master_byteenable;
  logic [DW-1:0] master_writedata;
  logic          master_waitrequest;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // One cycle of stimulus and the outputs expected during that same cycle.
  typedef struct packed {
    logic          rst;
    logic          go;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic          fixed;
    logic          push;
    logic [DW-1:0] data;
    logic          wreq;
    logic          e_done;
    logic          e_write;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_full;
  } vec_t;

  vec_t tbl[$];

  avalon_write_master dut (
    .clk                    (clk),
    .reset                  (reset),
    .control_fixed_location (control_fixed_location),
    .control_write_base     (control_write_base),
    .control_write_length   (control_write_length),
    .control_go             (control_go),
    .control_done           (control_done),
    .user_write_buffer      (user_write_buffer),
    .user_buffer_data       (user_buffer_data),
    .user_buffer_full       (user_buffer_full),
    .master_address         (master_address),
    .master_write           (master_write),
    .master_byteenable      (master_byteenable),
    .master_writedata       (master_writedata),
    .master_waitrequest     (master_waitrequest)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic go, input logic [AW-1:0] base,
                               input logic [AW-1:0] len, input logic fixed,
                               input logic push, input logic [DW-1:0] data,
                               input logic wreq, input logic e_done,
                               input logic e_write, input logic [AW-1:0] e_addr,
                               input logic [DW-1:0] e_data, input logic e_full);
    vec_t v;
    v.rst = 1'b1;   v.go = go;          v.base = base;     v.len = len;
    v.fixed = fixed; v.push = push;     v.data = data;     v.wreq = wreq;
    v.e_done = e_done; v.e_write = e_write; v.e_addr = e_addr;
    v.e_data = e_data; v.e_full = e_full;
    return v;
  endfunction

  // Idle-cycle shorthand: no go, optional push.
  function automatic vec_t idl(input logic push, input logic [DW-1:0] data,
                               input logic wreq, input logic e_done,
                               input logic e_write, input logic [AW-1:0] e_addr,
                               input logic [DW-1:0] e_data, input logic e_full);
    return mkv(1'b0, '0, '0, 1'b0, push, data, wreq, e_done, e_write, e_addr, e_data, e_full);
  endfunction

  task automatic check_val(input string name, input logic [DW-1:0] actual,
                           input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL step %0d %s: got %h expected %h", step_no, name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset                  = v.rst;
    control_go             = v.go;
    control_write_base     = v.base;
    control_write_length   = v.len;
    control_fixed_location = v.fixed;
    user_write_buffer      = v.push;
    user_buffer_data       = v.data;
    master_waitrequest     = v.wreq;
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    check_val("control_done", DW'(control_done), DW'(v.e_done));
    check_val("master_write", DW'(master_write), DW'(v.e_write));
    check_val("user_buffer_full", DW'(user_buffer_full), DW'(v.e_full));
    check_val("master_byteenable", DW'(master_byteenable), DW'(4'hF));
    if (v.e_write) begin
      check_val("master_address", DW'(master_address), DW'(v.e_addr));
      check_val("master_writedata", master_writedata, v.e_data);
    end
  endtask

  task automatic run_vec(input vec_t v);
    step_no++;
    applyStimulus(v);
    checkOutput(v);
  endtask

  initial begin
    vec_t v;

    // Single word, go and push in the same cycle, fixed address.
    tbl.push_back(mkv(1, 28'h8000004, 28'd4, 1, 1, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 0, 1, 28'h8000004, 32'hDEADBEEF, 0));
    tbl.push_back(idl(0, 0, 0, 1, 0, 0, 0, 0));
    // Zero length and sub-word length: done low for exactly one cycle.
    tbl.push_back(mkv(1, 28'h40, 28'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 28'h40, 28'd3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 1, 0, 0, 0, 0));
    // Address wraps modulo 2^28.
    tbl.push_back(idl(1, 32'hA1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 28'hFFFFFFC, 28'd8, 0, 1, 32'hA2, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 0, 1, 28'hFFFFFFC, 32'hA1, 0));
    tbl.push_back(idl(0, 0, 0, 0, 1, 28'h0000000, 32'hA2, 0));
    tbl.push_back(idl(0, 0, 0, 1, 0, 0, 0, 0));
    // Fixed address, length 10 rounds down to 8, go during XFER ignored.
    tbl.push_back(idl(1, 32'hB1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 28'h40, 28'd10, 1, 1, 32'hB2, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 28'h999, 28'd100, 0, 0, 0, 0, 0, 1, 28'h40, 32'hB1, 0));
    tbl.push_back(idl(0, 0, 0, 0, 1, 28'h40, 32'hB2, 0));
    tbl.push_back(idl(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 1, 0, 0, 0, 0));
    // Leftover word kept for the next transfer.
    tbl.push_back(idl(1, 32'hE1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idl(1, 32'hE2, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 28'h600, 28'd4, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 0, 1, 28'h600, 32'hE1, 0));
    tbl.push_back(idl(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 28'h700, 28'd4, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 0, 1, 28'h700, 32'hE2, 0));
    tbl.push_back(idl(0, 0, 0, 1, 0, 0, 0, 0));

    reset = 1'b0;
    control_go = 1'b0;
    control_write_base = '0;
    control_write_length = '0;
    control_fixed_location = 1'b0;
    user_write_buffer = 1'b0;
    user_buffer_data = '0;
    master_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset control_done", DW'(control_done), 32'd1);
    check_val("reset master_write", DW'(master_write), 32'd0);
    check_val("reset user_buffer_full", DW'(user_buffer_full), 32'd0);
    check_val("reset master_address", DW'(master_address), 32'd0);

    $display("[TB] directed table: %0d vectors", tbl.size());
    foreach (tbl[i]) run_vec(tbl[i]);

    // Incrementing burst with a 3-cycle stall on word 2.
    $display("[TB] burst with stalls");
    for (int i = 1; i <= 4; i++) run_vec(idl(1, DW'(i), 0, 1, 0, 0, 0, 0));
    run_vec(mkv(1, 28'h100, 28'd16, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    run_vec(idl(0, 0, 0, 0, 1, 28'h100, 32'h1, 0));
    for (int i = 0; i < 3; i++) run_vec(idl(0, 0, 1, 0, 1, 28'h104, 32'h2, 0));
    run_vec(idl(0, 0, 0, 0, 1, 28'h104, 32'h2, 0));
    run_vec(idl(0, 0, 0, 0, 1, 28'h108, 32'h3, 0));
    run_vec(idl(0, 0, 0, 0, 1, 28'h10C, 32'h4, 0));
    run_vec(idl(0, 0, 0, 1, 0, 0, 0, 0));

    // Overflow: 17 pushes, the last one is dropped.
    $display("[TB] overflow");
    for (int i = 0; i < 17; i++) run_vec(idl(1, 32'h100 + DW'(i), 0, 1, 0, 0, 0, i >= 16));
    run_vec(mkv(1, 28'h2000, 28'd64, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    for (int k = 0; k < 16; k++)
      run_vec(idl(0, 0, 0, 0, 1, 28'h2000 + AW'(4 * k), 32'h100 + DW'(k), k == 0));
    run_vec(idl(0, 0, 0, 1, 0, 0, 0, 0));

    // Starved FIFO: no write until data arrives; push and pop together.
    $display("[TB] starved fifo");
    run_vec(mkv(1, 28'h3000, 28'd8, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) run_vec(idl(0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(idl(1, 32'h51, 0, 0, 0, 0, 0, 0));
    run_vec(idl(1, 32'h52, 0, 0, 1, 28'h3000, 32'h51, 0));
    run_vec(idl(0, 0, 0, 0, 1, 28'h3004, 32'h52, 0));
    run_vec(idl(0, 0, 0, 1, 0, 0, 0, 0));

    // Reset mid-transfer with two words pending.
    $display("[TB] reset mid-transfer");
    run_vec(idl(1, 32'hC1, 0, 1, 0, 0, 0, 0));
    run_vec(idl(1, 32'hC2, 0, 1, 0, 0, 0, 0));
    run_vec(mkv(1, 28'h300, 28'd12, 0, 1, 32'hC3, 0, 1, 0, 0, 0, 0));
    run_vec(idl(0, 0, 0, 0, 1, 28'h300, 32'hC1, 0));
    v = idl(0, 0, 1, 0, 1, 28'h304, 32'hC2, 0);
    v.rst = 1'b0;
    run_vec(v);
    run_vec(idl(0, 0, 0, 1, 0, 0, 0, 0));
    check_val("post-reset master_address", DW'(master_address), 32'd0);
    run_vec(mkv(1, 28'h500, 28'd4, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    run_vec(idl(0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(idl(1, 32'hD1, 0, 0, 0, 0, 0, 0));
    run_vec(idl(0, 0, 0, 0, 1, 28'h500, 32'hD1, 0));
    run_vec(idl(0, 0, 0, 1, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_write_master.md
# avalon_write_master

Avalon-MM write master that executes write requests issued by the mining-core user logic. It latches a base address and byte length on `control_go` and buffers user data in an internal show-ahead FIFO. It drains that data to the memory fabric one word per accepted bus cycle, honouring `master_waitrequest`, and raises `control_done` when the last word is accepted. It sits between the user-logic write port and the SDRAM/on-chip memory interconnect, and implements the control/buffer contract the user logic already drives.

## Interface
- `ADDRESSWIDTH`, 28, byte-address width of base, length and bus address.
- `DATAWIDTH`, 32, data word width.
- `BYTEENABLEWIDTH`, 4, bytes per word (`DATAWIDTH/8`); address increment and length decrement step.
- `FIFODEPTH`, 16, user buffer depth in words (power of 2).
- `FIFODEPTHLOG2`, 4, log2(`FIFODEPTH`).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `control_fixed_location`  in  1  1 = do not increment the address between words.
- `control_write_base`  in  ADDRESSWIDTH  start byte address.
- `control_write_length`  in  ADDRESSWIDTH  transfer byte count, a multiple of `BYTEENABLEWIDTH`.
- `control_go`  in  1  single-cycle start strobe.
- `control_done`  out  1  high while idle; low from the edge that samples go until the last word is accepted.
- `user_write_buffer`  in  1  push `user_buffer_data` into the FIFO.
- `user_buffer_data`  in  DATAWIDTH  push data.
- `user_buffer_full`  out  1  FIFO holds `FIFODEPTH` words.
- `master_address`  out  ADDRESSWIDTH  bus byte address.
- `master_write`  out  1  bus write request.
- `master_byteenable`  out  BYTEENABLEWIDTH  always all ones.
- `master_writedata`  out  DATAWIDTH  FIFO head word.
- `master_waitrequest`  in  1  slave stall.

## Operation
- **States.**
  - IDLE: `control_done`=1, `master_write`=0.
  - XFER: words remain to be sent.
- **IDLE → XFER** on `control_go`.
  - Latch `address` <= base.
  - Latch `remaining` <= length with its low log2(`BYTEENABLEWIDTH`) bits cleared.
  - Latch `fixed` <= `control_fixed_location`.
  - Clear `control_done`.
- **`control_go` in XFER** is ignored and no latched value changes.
- **Bus write.** `master_write` = XFER & FIFO non-empty & `remaining`≠0.
  - `master_address` = `address`.
  - `master_writedata` = FIFO head.
- **Accept** is `master_write` & !`master_waitrequest`. On accept:
  - pop the FIFO;
  - `remaining` -= `BYTEENABLEWIDTH`;
  - `address` += `BYTEENABLEWIDTH` unless `fixed`, wrapping modulo 2^ADDRESSWIDTH.
- **XFER → IDLE** when `remaining` is 0: on the accept of the last word, or immediately if the latched length was 0.
  - `control_done` is 1 from the next cycle and held until the next go.
- **Zero length.** A go with length < `BYTEENABLEWIDTH` gives `control_done` low for exactly one cycle and no bus write.
- **FIFO push and full.**
  - A push is accepted when `user_buffer_full`=0, in any state, including the same cycle as go.
  - A push while full is dropped; FIFO contents and count do not change.
  - `user_buffer_full` is registered from the count.
  - Push and pop in the same cycle (not full) leaves the count unchanged and keeps data order.
- **Leftover data.** Words left in the FIFO after a transfer are kept for the next transfer.
- **Reset** (`reset`=0 at an edge) takes priority over everything, including mid-transfer:
  - state IDLE, FIFO emptied, `remaining`=0, `address`=0;
  - `control_done`=1, `user_buffer_full`=0, `master_write`=0, `master_address`=0;
  - `master_writedata` is don't-care while the FIFO is empty.

## Timing
- **Go-to-write latency.** Go sampled at edge N with the data word pushed at edge N or earlier:
  - `master_write` is high in cycle N+1;
  - with no waitrequest, `control_done`=1 in cycle N+2.
- **Stall.** While `master_waitrequest`=1 and `master_write`=1, `master_address`, `master_writedata` and `master_write` stay stable.
- **FIFO.** A push at edge K is visible at the FIFO head in cycle K+1 (show-ahead).
- **Throughput.** One word per cycle when the FIFO is non-empty and waitrequest is low.
- **FIFO empty mid-transfer.** `master_write` drops and the master stays in XFER with `control_done`=0 until data arrives.

## Test plan
- **Single word.** Push 0xDEADBEEF and pulse go (base 0x8000004, length 4, fixed 1) in the same cycle, waitrequest 0 → one write of 0xDEADBEEF to 0x8000004 in cycle N+1; `control_done` low in cycle N+1, high from N+2.
- **Incrementing burst with stalls.** Push 4 words 0x1..0x4, go with base 0x100, length 16, fixed 0; waitrequest high for 3 cycles on word 2 → writes to 0x100/0x104/0x108/0x10C with data 0x1..0x4; address and data held during the stall; done after the 4th accept.
- **Overflow.** Push 17 words with no go → `user_buffer_full`=1 after 16; 17th dropped; a go with length 64 then writes exactly words 1..16.
- **Starved FIFO.** Go with length 8 and an empty FIFO → `master_write`=0 and done=0 until a push; write 1 then write 2; done high after word 2.
- **Edge cases.** Go with length 0 → done low for 1 cycle, no write. Base 0xFFFFFFC with length 8, fixed 0 → addresses 0xFFFFFFC then 0x0000000.
- **Reset mid-transfer.** Assert reset mid-transfer with 2 words pending → next cycle `master_write`=0, done=1, full=0, FIFO empty; a following transfer behaves as after power-up.
